// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and helpers for the boot-time program loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAD,
        ACCEPT,
        WRITE,
        HOLD,
        DONE,
        ERROR
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Byte k of a word in big-endian order: k=0 is the MSB.
    function automatic logic [7:0] get_be_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/loader_byte_serializer.sv
// rtl/loader_byte_serializer.sv - turns one 32-bit word into four big-endian byte writes
module loader_byte_serializer
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [31:0]       word,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wdata,
    output logic              done
);

    logic [1:0]  k;
    logic [31:0] word_q;

    // we doubles as the busy flag; a go while busy is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            k      <= 2'd0;
            word_q <= 32'h0;
            we     <= 1'b0;
            addr   <= '0;
            wdata  <= 8'h00;
        end else if (!we) begin
            if (go) begin
                k      <= 2'd0;
                word_q <= word;
                we     <= 1'b1;
                addr   <= base_addr;
                wdata  <= get_be_byte(word, 2'd0);
            end
        end else if (k == 2'd3) begin
            k     <= 2'd0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= 8'h00;
        end else begin
            k     <= k + 2'd1;
            addr  <= addr + ADDR_W'(1);
            wdata <= get_be_byte(word_q, k + 2'd1);
        end
    end

    assign done = we && (k == 2'd3);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams instruction words into byte memory and holds the core in reset meanwhile
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int MEM_BYTES       = 1024,
    parameter int BASE_ADDR       = 0,
    parameter int PAD_NOP         = 1,
    parameter int CORE_RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [ADDR_W:0] BASE_P     = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] MEM_LIM    = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] WORD_BYTES = (ADDR_W+1)'(4);
    localparam logic [15:0]     HOLD_LAST  = 16'(CORE_RST_CYCLES - 1);

    state_t              state, state_n;
    logic [ADDR_W:0]     ptr, ptr_n;
    logic [ADDR_W-1:0]   wc_n;
    logic                last_q, last_n;
    logic [15:0]         hold_cnt, hold_n;

    logic                ser_go;
    logic [31:0]         ser_word;
    logic [ADDR_W-1:0]   ser_addr;
    logic                ser_done;

    loader_byte_serializer #(.ADDR_W(ADDR_W)) u_ser (
        .clk       (clk),
        .reset     (reset),
        .go        (ser_go),
        .word      (ser_word),
        .base_addr (ser_addr),
        .we        (mem_we),
        .addr      (mem_addr),
        .wdata     (mem_wdata),
        .done      (ser_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= BASE_P;
            word_count <= '0;
            last_q     <= 1'b0;
            hold_cnt   <= 16'd0;
            in_ready   <= 1'b0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            word_count <= wc_n;
            last_q     <= last_n;
            hold_cnt   <= hold_n;
            // Outputs are decoded from the next state so they line up with it.
            in_ready   <= (state_n == ACCEPT);
            core_reset <= (state_n != DONE);
            done       <= (state_n == DONE);
            err        <= (state_n == ERROR);
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        wc_n     = word_count;
        last_n   = last_q;
        hold_n   = hold_cnt;
        ser_go   = 1'b0;
        ser_word = NOP_WORD;
        ser_addr = BASE_P[ADDR_W-1:0];
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    ptr_n  = BASE_P;
                    wc_n   = '0;
                    hold_n = 16'd0;
                    if (PAD_NOP != 0) begin
                        state_n = PAD;
                        ser_go  = 1'b1;
                    end else begin
                        state_n = ACCEPT;
                    end
                end
            end
            PAD: begin
                if (ser_done) begin
                    ptr_n   = BASE_P + WORD_BYTES;
                    state_n = ACCEPT;
                end
            end
            ACCEPT: begin
                if (in_valid && in_ready) begin
                    last_n = in_last;
                    if (ptr + WORD_BYTES > MEM_LIM) begin
                        state_n = ERROR;
                    end else begin
                        state_n  = WRITE;
                        ser_go   = 1'b1;
                        ser_word = in_data;
                        ser_addr = ptr[ADDR_W-1:0];
                    end
                end
            end
            WRITE: begin
                if (ser_done) begin
                    ptr_n   = ptr + WORD_BYTES;
                    wc_n    = word_count + ADDR_W'(1);
                    hold_n  = 16'd0;
                    state_n = last_q ? HOLD : ACCEPT;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n = DONE;
                end else begin
                    hold_n = hold_cnt + 16'd1;
                end
            end
            ERROR: begin
                state_n = ERROR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time loader that sits directly upstream of the single-cycle core and its byte-wide main memory. It takes 32-bit instruction words from a valid/ready stream and splits each word into four big-endian byte writes, so the word's MSB goes to the lowest address. It keeps the core held in reset while loading and releases it once the load is complete. This replaces hierarchical memory preloading with a synthesizable load path.

Parameters:
ADDR_W, 10, byte-address width of main memory port
MEM_BYTES, 1024, memory size in bytes; writes at or above this address are illegal
BASE_ADDR, 0, byte address of the first write; must be a multiple of 4
PAD_NOP, 1, when 1, writes one all-zero word at BASE_ADDR before the stream, because the core skips its first fetch
CORE_RST_CYCLES, 4, number of cycles core_reset stays high after the last byte write (minimum 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
in_valid  in  1  in_data/in_last are valid
in_ready  out  1  loader can accept a word this cycle
in_data  in  32  instruction word
in_last  in  1  marks the final word of the program
mem_we  out  1  byte write enable to main memory
mem_addr  out  ADDR_W  byte address
mem_wdata  out  8  byte data
core_reset  out  1  active-high reset to the core
done  out  1  load finished and core released
err  out  1  address overflow; sticky until reset
word_count  out  ADDR_W  number of stream words written (PAD word excluded)

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, core_reset=1, done=0, err=0, word_count=0, ptr=BASE_ADDR. Reset mid-load aborts immediately; bytes already written stay in memory.
- All outputs are registered. in_ready is a Moore output: 1 only in ACCEPT.
- States:
  - IDLE: core_reset=1. On start, go to PAD if PAD_NOP=1, otherwise ACCEPT.
  - PAD: 4 cycles, each with mem_we=1, mem_addr=BASE_ADDR+k (k=0..3), mem_wdata=0. Then ptr=BASE_ADDR+4 and go to ACCEPT.
  - ACCEPT: in_ready=1. A handshake occurs when in_valid and in_ready are both 1. On handshake, latch data and last.
    - If ptr+4 > MEM_BYTES, go to ERROR with no write.
    - Otherwise go to WRITE.
    - in_valid=0 keeps the state unchanged; there is no timeout.
  - WRITE: 4 cycles, k=0..3, each with mem_we=1, mem_addr=ptr+k, mem_wdata=buf[31-8k -: 8]. On k=3: ptr+=4, word_count+=1, then go to HOLD if last was latched, otherwise ACCEPT. One word therefore costs 5 cycles (1 accept + 4 writes).
  - HOLD: core_reset=1 for exactly CORE_RST_CYCLES cycles, then go to DONE.
  - DONE: core_reset=0, done=1. A start here reasserts core_reset=1, clears done and word_count, sets ptr=BASE_ADDR, and enters PAD/ACCEPT on the next cycle.
  - ERROR: err=1, core_reset=1, in_ready=0, mem_we=0. Left only by reset.
- start outside IDLE/DONE is ignored.
- in_last on the first word is legal (single-word program).
- mem_addr and mem_wdata are 0 whenever mem_we=0.
- ptr arithmetic is ADDR_W+1 bits wide so the overflow compare cannot wrap.

Decomposition:
- Shared package loader_pkg holds:
  - state enum {IDLE, PAD, ACCEPT, WRITE, HOLD, DONE, ERROR}
  - NOP_WORD=32'h0000_0000
  - byte-select function get_be_byte(word, k)
- One sub-module, loader_byte_serializer: takes a 32-bit word plus a go pulse, emits 4 sequential big-endian byte writes, and returns a done pulse. It is used by both PAD and WRITE.

Test Plan:
- PAD_NOP=1, start, stream 0x06400a13 with last=1 → mem[0..3]=00 00 00 00, mem[4..7]=06 40 0A 13; core_reset falls exactly 4 cycles after the final byte write; done=1; word_count=1.
- Three words 0x06400a13, 0xfeca0a93, 0x05000b13, with in_valid deasserted for 3 cycles between words → in_ready=1 only in ACCEPT; bytes land at 4..15 in order; no extra writes during gaps; word_count=3.
- MEM_BYTES=12, PAD_NOP=1, stream 3 words → first 2 words written (addr 4..11); the 3rd handshake sets err=1 with no mem_we; core_reset stays 1 and done stays 0.
- reset=0 during WRITE byte k=1 → next cycle mem_we=0, core_reset=1, state IDLE; a new start reloads from BASE_ADDR.
- start pulsed during ACCEPT → ignored (ptr and word_count unchanged). start in DONE → core_reset rises the next cycle and the load restarts.
- PAD_NOP=0, BASE_ADDR=16, one word 0xfe9ff56f → mem[16..19]=FE 9F F5 6F; no write below 16.
